// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART transmitter.
package uart_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous byte FIFO; read data is presented combinationally from the head entry.
module uart_host_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: byte FIFO feeding 8N1 frames with CTS flow control.
// Define UART_HOST_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_host_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        uart_cts,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    import uart_host_pkg::*;

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic [15:0]    frames_q, frames_d;
    logic           cts_meta_q, cts_sync_q;
    logic           pop_c;
    logic           bit_end_c;
    logic           start_ok_c;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
`ifdef UART_HOST_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    uart_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_valid),
        .wdata (wr_data),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end_c  = (baud_q == BAUD_LAST);
    assign start_ok_c = ~fifo_empty & ~cts_sync_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end_c ? '0 : baud_q + BW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        frames_d = frames_q;
        pop_c    = 1'b0;
`ifdef UART_HOST_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (start_ok_c) begin
                    pop_c    = 1'b1;
                    shift_d  = fifo_rdata;
`ifdef UART_HOST_TX_PARITY_EN
                    parity_d = even_parity(fifo_rdata);
`endif
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        idx_d   = '0;
`ifdef UART_HOST_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_d = STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        frames_d = frames_q + 16'(1);
                        // Back-to-back frames restart without an idle gap.
                        if (start_ok_c) begin
                            pop_c    = 1'b1;
                            shift_d  = fifo_rdata;
`ifdef UART_HOST_TX_PARITY_EN
                            parity_d = even_parity(fifo_rdata);
`endif
                            tx_d     = 1'b0;
                            state_d  = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            frames_q   <= '0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
`ifdef UART_HOST_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            frames_q   <= frames_d;
            cts_meta_q <= uart_cts;
            cts_sync_q <= cts_meta_q;
`ifdef UART_HOST_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_tx     = tx_q;
    assign frames_sent = frames_q;
    assign wr_ready    = ~fifo_full;
    assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_host_tx;

`ifdef UART_HOST_TX_PARITY_EN
    localparam int NB = 11;
    localparam int NV = 6;
`else
    localparam int NB = 10;
    localparam int NV = 4;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        uart_cts;
    logic        uart_tx;
    logic        busy;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    uart_host_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .uart_cts    (uart_cts),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_HOST_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    // Entered just after the edge that starts the frame; exits after the edge ending the stop bit.
    task automatic check_frame(input logic [10:0] frame, input int raise_at, input string nm);
        for (int k = 0; k < NB; k++) begin
            if (k == raise_at) begin
                uart_cts = 1'b1;
            end
            chk($sformatf("%s_b%0d_first", nm, k), 32'(uart_tx), 32'(frame[k]));
            tick(3);
            chk($sformatf("%s_b%0d_last", nm, k), 32'(uart_tx), 32'(frame[k]));
            tick(1);
        end
    endtask

    initial begin
        logic [7:0] fc_bytes [5];

`ifdef UART_HOST_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b10101001010};
        vecs[1] = '{8'h3C, 11'b10001111000};
        vecs[2] = '{8'h01, 11'b11000000010};
        vecs[3] = '{8'h80, 11'b11100000000};
        vecs[4] = '{8'h07, 11'b11000001110};
        vecs[5] = '{8'h03, 11'b10000000110};
`else
        vecs[0] = '{8'hA5, 11'b01101001010};
        vecs[1] = '{8'h3C, 11'b01001111000};
        vecs[2] = '{8'h01, 11'b01000000010};
        vecs[3] = '{8'h80, 11'b01100000000};
`endif
        fc_bytes[0] = 8'h00;
        fc_bytes[1] = 8'hFF;
        fc_bytes[2] = 8'h55;
        fc_bytes[3] = 8'h3C;
        fc_bytes[4] = 8'hA5;

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        uart_cts = 1'b0;
        tick(3);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        reset = 1'b0;
        tick(4);

        // Single frames from the vector table.
        for (int i = 0; i < NV; i++) begin
            push(vecs[i].data);
            chk($sformatf("v%0d_tx_after_write", i), 32'(uart_tx), 32'd1);
            tick(1);
            check_frame(vecs[i].frame, -1, $sformatf("v%0d", i));
            chk($sformatf("v%0d_frames", i), 32'(frames_sent), 32'(i + 1));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Flow control hold, FIFO full refusal, then back-to-back release.
        uart_cts = 1'b1;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            wr_data  = fc_bytes[i];
            wr_valid = 1'b1;
            chk($sformatf("fc_wr_ready_%0d", i), 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
            tick(1);
        end
        wr_valid = 1'b0;
        chk("fc_full", 32'(wr_ready), 32'd0);
        chk("fc_busy_held", 32'(busy), 32'd1);
        tick(10);
        chk("fc_tx_held", 32'(uart_tx), 32'd1);
        uart_cts = 1'b0;
        tick(2);
        chk("fc_sync_latency", 32'(uart_tx), 32'd1);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check_frame(mk_frame(fc_bytes[i]), -1, $sformatf("fc%0d", i));
        end
        chk("fc_frames", 32'(frames_sent), 32'(NV + 4));
        chk("fc_busy_done", 32'(busy), 32'd0);
        chk("fc_wr_ready_done", 32'(wr_ready), 32'd1);
        chk("fc_tx_idle", 32'(uart_tx), 32'd1);

        // CTS raised mid-frame: frame completes, next one waits.
        uart_cts = 1'b1;
        tick(3);
        push(8'h3C);
        push(8'h81);
        uart_cts = 1'b0;
        tick(3);
        check_frame(mk_frame(8'h3C), 4, "mid");
        chk("mid_tx_idle", 32'(uart_tx), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        tick(8);
        chk("mid_tx_wait", 32'(uart_tx), 32'd1);
        uart_cts = 1'b0;
        tick(2);
        chk("mid_sync_latency", 32'(uart_tx), 32'd1);
        tick(1);
        check_frame(mk_frame(8'h81), -1, "mid2");
        chk("mid_frames", 32'(frames_sent), 32'(NV + 6));

        // Reset during data bit 5 abandons the frame and flushes the FIFO.
        wr_data  = 8'h0F;
        wr_valid = 1'b1;
        tick(1);
        wr_data  = 8'h11;
        tick(1);
        wr_valid = 1'b0;
        tick(25);
        chk("rstmid_bit5", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        tick(1);
        chk("rstmid_tx", 32'(uart_tx), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_frames", 32'(frames_sent), 32'd0);
        chk("rstmid_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        tick(12);
        chk("rstmid_tx_quiet", 32'(uart_tx), 32'd1);
        chk("rstmid_busy_quiet", 32'(busy), 32'd0);
        push(8'hA5);
        tick(1);
        check_frame(mk_frame(8'hA5), -1, "post");
        chk("post_frames", 32'(frames_sent), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
